fetch_sequencer: RTL and testbench

- Instruction-fetch and sequencing stage that sits directly upstream of the program memory.
- Owns the program counter and drives `pc` into the memory; the memory's combinational `ir` output returns in the same cycle.
- Resolves control-flow instructions internally: GOTO, IFZ (skip N if zero), IFNZ (skip N if not zero).
- Issues all other instructions to the execute stage through a valid/ready handshake.

---
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns the PC, resolves GOTO/IFZ/IFNZ locally, issues the rest.
// Optional build macro FETCH_HALT_ON_SELF_GOTO_EN adds a `halted` output and a HALT state for self-GOTOs.
module fetch_sequencer #(
   parameter int                  PC_WIDTH = 8,
   parameter int                  IR_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                res_n,
   output logic [PC_WIDTH-1:0] pc,
   input  logic [IR_WIDTH-1:0] ir,
   input  logic                zero_flag,
   input  logic                flag_valid,
   output logic [IR_WIDTH-1:0] ex_ir,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic                branch_taken,
`ifdef FETCH_HALT_ON_SELF_GOTO_EN
   output logic                halted,
`endif
   output logic [1:0]          fsm_state
);

   // Handshake: ex_ir is transferred on a rising edge where ex_valid and ex_ready are both 1;
   // while ex_valid=1 and ex_ready=0, ex_ir and ex_valid are held unchanged.

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      COND  = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [4:0] OP_GOTO = 5'b10000;
   localparam logic [4:0] OP_IFZ  = 5'b10001;
   localparam logic [4:0] OP_IFNZ = 5'b10010;

   state_t              state;
   logic                cond_ifz;
   logic [7:0]          cond_n;

   logic [4:0]          op;
   logic                is_goto;
   logic                is_cond;
   logic                self_goto;
   logic                do_classify;
   logic                take;
   logic [PC_WIDTH-1:0] target;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] pc_skip;

   assign op          = ir[15:11];
   assign is_goto     = (op == OP_GOTO);
   assign is_cond     = (op == OP_IFZ) || (op == OP_IFNZ);
   assign target      = ir[PC_WIDTH-1:0];
   assign pc_inc      = pc + PC_WIDTH'(1);
   assign pc_skip     = pc + PC_WIDTH'(1) + PC_WIDTH'(cond_n);
   assign take        = cond_ifz ? zero_flag : ~zero_flag;
   assign do_classify = (state == FETCH) || ((state == ISSUE) && ex_ready);
   assign fsm_state   = state;

`ifdef FETCH_HALT_ON_SELF_GOTO_EN
   assign self_goto = is_goto && (target == pc);
`else
   assign self_goto = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!res_n) begin
         pc           <= RESET_PC;
         ex_ir        <= '0;
         ex_valid     <= 1'b0;
         branch_taken <= 1'b0;
         state        <= FETCH;
         cond_ifz     <= 1'b0;
         cond_n       <= '0;
`ifdef FETCH_HALT_ON_SELF_GOTO_EN
         halted       <= 1'b0;
`endif
      end else begin
         branch_taken <= 1'b0;
         if (do_classify) begin
            if (self_goto) begin
               // A self-GOTO can never leave itself; park until reset instead of spinning.
               ex_valid <= 1'b0;
               state    <= HALT;
`ifdef FETCH_HALT_ON_SELF_GOTO_EN
               halted   <= 1'b1;
`endif
            end else if (is_goto) begin
               pc           <= target;
               branch_taken <= 1'b1;
               ex_valid     <= 1'b0;
               state        <= FETCH;
            end else if (is_cond) begin
               // pc stays on the conditional until the flag can be trusted.
               cond_ifz <= (op == OP_IFZ);
               cond_n   <= ir[7:0];
               ex_valid <= 1'b0;
               state    <= COND;
            end else begin
               ex_ir    <= ir;
               ex_valid <= 1'b1;
               pc       <= pc_inc;
               state    <= ISSUE;
            end
         end else if ((state == COND) && flag_valid) begin
            pc           <= take ? pc_skip : pc_inc;
            branch_taken <= take;
            state        <= FETCH;
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: issued words go through an expected queue checked by a monitor,
// PC / branch pulses / FSM state are checked against hand-computed values along one scripted program.
module tb_fetch_sequencer;

   logic        clk;
   logic        res_n;
   logic [7:0]  pc;
   logic [15:0] ir;
   logic        zero_flag;
   logic        flag_valid;
   logic [15:0] ex_ir;
   logic        ex_valid;
   logic        ex_ready;
   logic        branch_taken;
   logic [1:0]  fsm_state;
`ifdef FETCH_HALT_ON_SELF_GOTO_EN
   logic        halted;
`endif

   logic [15:0] mem [256];
   logic [15:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;

   assign ir = mem[pc];

   fetch_sequencer #(.PC_WIDTH(8), .IR_WIDTH(16), .RESET_PC(8'd0)) dut (
      .clk          (clk),
      .res_n        (res_n),
      .pc           (pc),
      .ir           (ir),
      .zero_flag    (zero_flag),
      .flag_valid   (flag_valid),
      .ex_ir        (ex_ir),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .branch_taken (branch_taken),
`ifdef FETCH_HALT_ON_SELF_GOTO_EN
      .halted       (halted),
`endif
      .fsm_state    (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: advance one rising edge, then settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor: one pop per completed handshake
   always @(negedge clk) begin
      if (res_n && ex_valid && ex_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got %h expected none", ex_ir);
         end else begin
            chk("issue_ir", {16'h0, ex_ir}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0]     = 16'h4903;
      mem[1]     = 16'h4A14;
      mem[2]     = 16'h4BF0;
      mem[3]     = 16'h4C01;
      mem[4]     = 16'h800A;  // GOTO 10
      mem[8]     = 16'h4E08;
      mem[9]     = 16'h80FE;  // GOTO FE
      mem[10]    = 16'h8802;  // IFZ 2
      mem[11]    = 16'h8014;  // GOTO 20
      mem[20]    = 16'h8801;  // IFZ 1
      mem[21]    = 16'h4D21;  // must be skipped
      mem[22]    = 16'h8008;  // GOTO 8
      mem[8'hFE] = 16'h9005;  // IFNZ 5

      res_n = 1'b0; ex_ready = 1'b1; flag_valid = 1'b0; zero_flag = 1'b0;
      step(); step();
      chk("rst_pc", {24'h0, pc}, 32'h0);
      chk("rst_valid", {31'h0, ex_valid}, 32'h0);
      chk("rst_bt", {31'h0, branch_taken}, 32'h0);
      chk("rst_state", {30'h0, fsm_state}, 32'h0);

      // back-to-back issue
      res_n = 1'b1;
      exp_q.push_back(16'h4903); exp_q.push_back(16'h4A14);
      exp_q.push_back(16'h4BF0); exp_q.push_back(16'h4C01);
      step();
      chk("issue1_valid", {31'h0, ex_valid}, 32'h1);
      chk("issue1_pc", {24'h0, pc}, 32'h1);
      step();
      chk("issue2_pc", {24'h0, pc}, 32'h2);
      step();
      chk("issue3_pc", {24'h0, pc}, 32'h3);
      step();
      chk("issue4_pc", {24'h0, pc}, 32'h4);

      // backpressure hold
      ex_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_pc", {24'h0, pc}, 32'h4);
         chk("hold_valid", {31'h0, ex_valid}, 32'h1);
         chk("hold_ir", {16'h0, ex_ir}, 32'h4C01);
      end
      ex_ready = 1'b1;
      step();  // handshake + GOTO 10
      chk("goto10_pc", {24'h0, pc}, 32'd10);
      chk("goto10_bt", {31'h0, branch_taken}, 32'h1);
      chk("goto10_valid", {31'h0, ex_valid}, 32'h0);

      // IFZ not taken, flag delayed
      step();
      chk("ifz_state", {30'h0, fsm_state}, 32'd2);
      chk("ifz_bt", {31'h0, branch_taken}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ifz_wait_pc", {24'h0, pc}, 32'd10);
      end
      flag_valid = 1'b1; zero_flag = 1'b0;
      step();
      chk("ifz_nt_pc", {24'h0, pc}, 32'd11);
      chk("ifz_nt_bt", {31'h0, branch_taken}, 32'h0);
      flag_valid = 1'b0;
      step();  // GOTO 20
      chk("goto20_pc", {24'h0, pc}, 32'd20);

      // IFZ taken, skip 1
      step();
      flag_valid = 1'b1; zero_flag = 1'b1;
      step();
      chk("ifz_t_pc", {24'h0, pc}, 32'd22);
      chk("ifz_t_bt", {31'h0, branch_taken}, 32'h1);
      flag_valid = 1'b0;
      step();  // GOTO 8
      chk("goto8_pc", {24'h0, pc}, 32'd8);
      chk("goto8_valid", {31'h0, ex_valid}, 32'h0);
      chk("goto8_bt", {31'h0, branch_taken}, 32'h1);
      exp_q.push_back(16'h4E08);
      step();
      chk("after_goto_bt", {31'h0, branch_taken}, 32'h0);
      chk("after_goto_valid", {31'h0, ex_valid}, 32'h1);
      chk("after_goto_pc", {24'h0, pc}, 32'd9);
      step();  // GOTO FE
      chk("gotofe_pc", {24'h0, pc}, 32'hFE);

      // IFNZ wrap past the end
      step();
      flag_valid = 1'b1; zero_flag = 1'b0;
      step();
      chk("wrap_pc", {24'h0, pc}, 32'h04);
      chk("wrap_bt", {31'h0, branch_taken}, 32'h1);
      flag_valid = 1'b0;
      step();  // GOTO 10
      step();  // IFZ -> COND
      chk("cond_again_state", {30'h0, fsm_state}, 32'd2);
      chk("cond_again_bt", {31'h0, branch_taken}, 32'h0);

      // reset while in COND; prepare self-GOTO program
      mem[0] = 16'h8005;
      mem[5] = 16'h8005;
      res_n = 1'b0;
      step();
      chk("rst_cond_pc", {24'h0, pc}, 32'h0);
      chk("rst_cond_valid", {31'h0, ex_valid}, 32'h0);
      chk("rst_cond_state", {30'h0, fsm_state}, 32'h0);
      res_n = 1'b1;
      step();  // GOTO 5
      chk("goto5_pc", {24'h0, pc}, 32'd5);
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("self_pc", {24'h0, pc}, 32'd5);
         chk("self_valid", {31'h0, ex_valid}, 32'h0);
`ifdef FETCH_HALT_ON_SELF_GOTO_EN
         chk("self_halted", {31'h0, halted}, 32'h1);
         chk("self_state", {30'h0, fsm_state}, 32'd3);
`else
         chk("self_bt", {31'h0, branch_taken}, 32'h1);
`endif
      end

      chk("queue_drained", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
